// File: rtl/hazard_pkg.sv
// Shared encodings and the register-match helper for the pipeline hazard stall unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_LOAD   = 2'd1,
    CAUSE_BRANCH = 2'd2,
    CAUSE_HILO   = 2'd3
  } stall_cause_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A producer register r hazards the ID instruction only if ID actually reads it; $0 never does.
  function automatic logic reg_match(input logic [4:0] r,
                                     input logic [4:0] rs, input logic uses_rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (r != REG_ZERO) && (((r == rs) && uses_rs) || ((r == rt) && uses_rt));
  endfunction

endpackage

// File: rtl/muldiv_busy_ctr.sv
// Countdown of cycles until HI/LO become readable after a mult/div leaves ID.
module muldiv_busy_ctr #(
  parameter int LAT   = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic busy
);

  logic [CNT_W-1:0] count;

  // Issue is only possible at zero, so load and decrement never compete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (issue) begin
      count <= CNT_W'(LAT);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end else begin
      count <= count;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for load-use, branch-in-ID and HI/LO busy hazards.
// Optional per-cause stall statistics are enabled by defining HAZARD_STATS_EN.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 3
`ifdef HAZARD_STATS_EN
  , parameter int STAT_W   = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic        D_uses_rs,
  input  logic        D_uses_rt,
  input  logic        D_is_branch,
  input  logic        D_br_taken,
  input  logic        D_is_muldiv,
  input  logic        D_reads_hilo,
  input  logic [4:0]  X_writeReg,
  input  logic        X_RW,
  input  logic        X_memRead,
  input  logic [4:0]  M_writeReg,
  input  logic        M_memRead,
  output logic        stall_F,
  output logic        stall_D,
  output logic        flush_X,
  output logic        flush_D,
  output logic [1:0]  stall_cause,
`ifdef HAZARD_STATS_EN
  output logic [STAT_W-1:0] stat_load,
  output logic [STAT_W-1:0] stat_branch,
  output logic [STAT_W-1:0] stat_hilo,
`endif
  output logic        muldiv_busy
);

  logic x_match;
  logic m_match;
  logic load_haz;
  logic branch_haz;
  logic hilo_haz;
  logic stall;
  stall_cause_t cause;

  assign x_match = reg_match(X_writeReg, D_rs, D_uses_rs, D_rt, D_uses_rt);
  assign m_match = reg_match(M_writeReg, D_rs, D_uses_rs, D_rt, D_uses_rt);

  // Branches compare in ID, so an EX ALU result or a MEM load result is still too late to bypass.
  assign load_haz   = X_memRead && x_match;
  assign branch_haz = D_is_branch && ((X_RW && x_match) || (M_memRead && m_match));
  assign hilo_haz   = (D_reads_hilo || D_is_muldiv) && muldiv_busy;
  assign stall      = load_haz || branch_haz || hilo_haz;

  muldiv_busy_ctr #(
    .LAT   (MULDIV_LAT),
    .CNT_W (CNT_W)
  ) u_busy_ctr (
    .clk   (clk),
    .rst   (rst),
    .issue (D_is_muldiv && !stall),
    .busy  (muldiv_busy)
  );

  // Cause priority: load over branch over HI/LO.
  always_comb begin
    cause = CAUSE_NONE;
    if (load_haz) begin
      cause = CAUSE_LOAD;
    end else if (branch_haz) begin
      cause = CAUSE_BRANCH;
    end else if (hilo_haz) begin
      cause = CAUSE_HILO;
    end else begin
      cause = CAUSE_NONE;
    end
  end

  assign stall_F     = stall;
  assign stall_D     = stall;
  assign flush_X     = stall;
  assign flush_D     = D_br_taken && !stall;
  assign stall_cause = cause;

`ifdef HAZARD_STATS_EN
  // Saturating per-cause stall-cycle counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_load   <= '0;
      stat_branch <= '0;
      stat_hilo   <= '0;
    end else begin
      case (cause)
        CAUSE_LOAD:   if (stat_load   != '1) stat_load   <= stat_load   + STAT_W'(1);
        CAUSE_BRANCH: if (stat_branch != '1) stat_branch <= stat_branch + STAT_W'(1);
        CAUSE_HILO:   if (stat_hilo   != '1) stat_hilo   <= stat_hilo   + STAT_W'(1);
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios plus randomized stimulus vs a rule-level model.
module tb_hazard_stall_unit;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] D_rs, D_rt, X_writeReg, M_writeReg;
  logic D_uses_rs, D_uses_rt, D_is_branch, D_br_taken, D_is_muldiv, D_reads_hilo;
  logic X_RW, X_memRead, M_memRead;
  logic stall_F, stall_D, flush_X, flush_D, muldiv_busy;
  logic [1:0] stall_cause;
`ifdef HAZARD_STATS_EN
  logic [31:0] stat_load, stat_branch, stat_hilo;
`endif

  hazard_stall_unit #(.MULDIV_LAT(LAT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .D_rs(D_rs), .D_rt(D_rt), .D_uses_rs(D_uses_rs), .D_uses_rt(D_uses_rt),
    .D_is_branch(D_is_branch), .D_br_taken(D_br_taken), .D_is_muldiv(D_is_muldiv),
    .D_reads_hilo(D_reads_hilo), .X_writeReg(X_writeReg), .X_RW(X_RW), .X_memRead(X_memRead),
    .M_writeReg(M_writeReg), .M_memRead(M_memRead),
    .stall_F(stall_F), .stall_D(stall_D), .flush_X(flush_X), .flush_D(flush_D),
    .stall_cause(stall_cause),
`ifdef HAZARD_STATS_EN
    .stat_load(stat_load), .stat_branch(stat_branch), .stat_hilo(stat_hilo),
`endif
    .muldiv_busy(muldiv_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Model: cycle number and the first cycle in which HI/LO are readable.
  longint cyc = 0;
  longint ready_cyc = 0;
  int m_load = 0, m_branch = 0, m_hilo = 0;

  function automatic bit uses(input logic [4:0] r);
    return r != 5'd0 && ((r == D_rs && D_uses_rs) || (r == D_rt && D_uses_rt));
  endfunction

  logic e_load, e_branch, e_hilo, e_stall, e_busy;
  logic [1:0] e_cause;
  always_comb begin
    e_busy   = (cyc < ready_cyc);
    e_load   = X_memRead && uses(X_writeReg);
    e_branch = D_is_branch && ((X_RW && uses(X_writeReg)) || (M_memRead && uses(M_writeReg)));
    e_hilo   = (D_reads_hilo || D_is_muldiv) && e_busy;
    e_stall  = e_load || e_branch || e_hilo;
    e_cause  = e_load ? 2'd1 : e_branch ? 2'd2 : e_hilo ? 2'd3 : 2'd0;
  end

  // Model state advance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_cyc <= 0;
      m_load <= 0; m_branch <= 0; m_hilo <= 0;
    end else begin
      cyc <= cyc + 1;
      if (D_is_muldiv && !e_stall) ready_cyc <= cyc + 1 + LAT;
      if (e_cause == 2'd1) m_load   <= m_load + 1;
      if (e_cause == 2'd2) m_branch <= m_branch + 1;
      if (e_cause == 2'd3) m_hilo   <= m_hilo + 1;
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("stall_F", 32'(stall_F), 32'(e_stall));
      check("stall_D", 32'(stall_D), 32'(e_stall));
      check("flush_X", 32'(flush_X), 32'(e_stall));
      check("flush_D", 32'(flush_D), 32'(D_br_taken && !e_stall));
      check("stall_cause", 32'(stall_cause), 32'(e_cause));
      check("muldiv_busy", 32'(muldiv_busy), 32'(e_busy));
`ifdef HAZARD_STATS_EN
      check("stat_load", stat_load, 32'(m_load));
      check("stat_branch", stat_branch, 32'(m_branch));
      check("stat_hilo", stat_hilo, 32'(m_hilo));
`endif
    end
  end

  task automatic idle();
    D_rs = 5'd0; D_rt = 5'd0; D_uses_rs = 1'b0; D_uses_rt = 1'b0;
    D_is_branch = 1'b0; D_br_taken = 1'b0; D_is_muldiv = 1'b0; D_reads_hilo = 1'b0;
    X_writeReg = 5'd0; X_RW = 1'b0; X_memRead = 1'b0; M_writeReg = 5'd0; M_memRead = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    #2;
    check("reset_stall", 32'(stall_F), 32'd0);
    check("reset_cause", 32'(stall_cause), 32'd0);
    check("reset_busy", 32'(muldiv_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // lw $2 in X, add reads $2: one-cycle load-use stall.
    next_cycle();
    X_memRead = 1'b1; X_RW = 1'b1; X_writeReg = 5'd2; D_rs = 5'd2; D_uses_rs = 1'b1; D_rt = 5'd5; D_uses_rt = 1'b1;
    @(negedge clk);
    check("lu_stall", 32'(stall_F), 32'd1);
    check("lu_cause", 32'(stall_cause), 32'd1);
    next_cycle();
    X_memRead = 1'b0; X_RW = 1'b0; X_writeReg = 5'd0; M_memRead = 1'b1; M_writeReg = 5'd2;
    @(negedge clk);
    check("lu_release", 32'(stall_F), 32'd0);
    check("lu_release_cause", 32'(stall_cause), 32'd0);

    // lw $2 in X, taken beq $2,$3 in D: load cycle, branch cycle, then flush.
    next_cycle();
    idle();
    X_memRead = 1'b1; X_RW = 1'b1; X_writeReg = 5'd2;
    D_is_branch = 1'b1; D_br_taken = 1'b1; D_rs = 5'd2; D_rt = 5'd3; D_uses_rs = 1'b1; D_uses_rt = 1'b1;
    @(negedge clk);
    check("br_c1_cause", 32'(stall_cause), 32'd1);
    check("br_c1_flushD", 32'(flush_D), 32'd0);
    next_cycle();
    X_memRead = 1'b0; X_RW = 1'b0; X_writeReg = 5'd0; M_memRead = 1'b1; M_writeReg = 5'd2;
    @(negedge clk);
    check("br_c2_cause", 32'(stall_cause), 32'd2);
    check("br_c2_flushD", 32'(flush_D), 32'd0);
    next_cycle();
    M_memRead = 1'b0; M_writeReg = 5'd0;
    @(negedge clk);
    check("br_c3_stall", 32'(stall_F), 32'd0);
    check("br_c3_flushD", 32'(flush_D), 32'd1);

    // Load to $0 never hazards.
    next_cycle();
    idle();
    X_memRead = 1'b1; X_writeReg = 5'd0; D_rs = 5'd0; D_uses_rs = 1'b1;
    @(negedge clk);
    check("zero_reg", 32'(stall_F), 32'd0);

    // mult then mflo: four HI/LO stall cycles.
    next_cycle();
    idle();
    D_is_muldiv = 1'b1;
    @(negedge clk);
    check("mult_issue", 32'(stall_F), 32'd0);
    for (int i = 0; i < LAT; i++) begin
      next_cycle();
      idle();
      D_reads_hilo = 1'b1;
      @(negedge clk);
      check("mflo_cause", 32'(stall_cause), 32'd3);
      check("mflo_busy", 32'(muldiv_busy), 32'd1);
    end
    next_cycle();
    @(negedge clk);
    check("mflo_go", 32'(stall_F), 32'd0);
    check("mflo_busy_drop", 32'(muldiv_busy), 32'd0);
`ifdef HAZARD_STATS_EN
    check("stat_load_lit", stat_load, 32'd2);
    check("stat_branch_lit", stat_branch, 32'd1);
    check("stat_hilo_lit", stat_hilo, 32'd4);
`endif

    // Reset with counter at 2 aborts the mult/div.
    next_cycle();
    idle();
    D_is_muldiv = 1'b1;
    next_cycle();
    idle();
    next_cycle();
    next_cycle();
    D_reads_hilo = 1'b1;
    #1;
    check("pre_rst_busy", 32'(muldiv_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(muldiv_busy), 32'd0);
    check("rst_stall", 32'(stall_F), 32'd0);
`ifdef HAZARD_STATS_EN
    check("rst_stat_hilo", stat_hilo, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    check("post_rst_mflo", 32'(stall_F), 32'd0);

    // Randomized traffic; small register range keeps matches frequent.
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      D_rs = 5'($urandom_range(0, 3)); D_rt = 5'($urandom_range(0, 3));
      D_uses_rs = 1'($urandom); D_uses_rt = 1'($urandom);
      D_is_branch = ($urandom_range(0, 3) == 0); D_br_taken = D_is_branch && 1'($urandom);
      D_is_muldiv = ($urandom_range(0, 7) == 0);
      D_reads_hilo = !D_is_muldiv && ($urandom_range(0, 3) == 0);
      X_writeReg = 5'($urandom_range(0, 3)); X_RW = 1'($urandom); X_memRead = X_RW && ($urandom_range(0, 2) == 0);
      M_writeReg = 5'($urandom_range(0, 3)); M_memRead = 1'($urandom);
    end
    next_cycle();
    idle();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
